// File: rtl/adder_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adder_seq_ctrl
//
// Multi-cycle wide adder controller. A DATA_WIDTH-bit add with carry-in is
// performed by stepping one SLICE_WIDTH-bit carry-lookahead slice
// (adder_xbit_ahead) across the operands over NUM_SLICES clock cycles. The
// least-significant slice goes first, and a registered carry links each slice
// to the next. Valid/ready handshakes on both sides allow the block to sit
// between an issue stage and its consumer.
//
// Ports (adder_seq_ctrl):
//   i_clk    in   1           clock, rising edge
//   i_rst    in   1           synchronous reset, active-high
//   i_valid  in   1           request valid
//   o_ready  out  1           controller can accept a request (IDLE)
//   i_num_a  in   DATA_WIDTH  operand a
//   i_num_b  in   DATA_WIDTH  operand b
//   i_cry    in   1           carry-in into bit 0
//   o_valid  out  1           result valid (DONE)
//   i_ready  in   1           consumer accepts result
//   o_res    out  DATA_WIDTH  sum mod 2^DATA_WIDTH
//   o_cry    out  1           carry out of bit DATA_WIDTH-1
//   o_busy   out  1           high while in CALC or DONE
//
// Ports (adder_xbit_ahead):
//   a_i, b_i  in   WIDTH  slice operands
//   cry_i     in   1      slice carry-in
//   sum_o     out  WIDTH  slice sum
//   cry_o     out  1      slice carry-out
// -----------------------------------------------------------------------------

// Carry-lookahead slice. Each carry is built as a flat sum of products of
// generate/propagate terms, so no carry ripples through the slice.
module adder_xbit_ahead #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cry_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cry_o
);

   logic [WIDTH-1:0] gen;
   logic [WIDTH-1:0] prop;
   logic [WIDTH:0]   cry;

   assign gen  = a_i & b_i;
   assign prop = a_i ^ b_i;

   // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
   always_comb begin
      logic acc;
      logic pprod;
      cry    = '0;
      cry[0] = cry_i;
      for (int i = 0; i < WIDTH; i++) begin
         acc   = 1'b0;
         pprod = 1'b1;
         for (int j = i; j >= 0; j--) begin
            acc   = acc | (pprod & gen[j]);
            pprod = pprod & prop[j];
         end
         acc        = acc | (pprod & cry_i);
         cry[i+1]   = acc;
      end
   end

   assign sum_o = prop ^ cry[WIDTH-1:0];
   assign cry_o = cry[WIDTH];

endmodule

module adder_seq_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int SLICE_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [DATA_WIDTH-1:0] i_num_a,
   input  logic [DATA_WIDTH-1:0] i_num_b,
   input  logic                  i_cry,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_res,
   output logic                  o_cry,
   output logic                  o_busy
);

   localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
   // Keep the counter at least one bit wide so NUM_SLICES=1 still elaborates.
   localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   if ((DATA_WIDTH % SLICE_WIDTH) != 0) begin : g_bad_width
      $error("adder_seq_ctrl: DATA_WIDTH must be a multiple of SLICE_WIDTH");
   end
   if (NUM_SLICES < 1) begin : g_bad_slices
      $error("adder_seq_ctrl: NUM_SLICES must be at least 1");
   end

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] opa_q, opa_d;
   logic [DATA_WIDTH-1:0] opb_q, opb_d;
   logic                  cry_q, cry_d;     // inter-slice carry
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  ocry_q, ocry_d;   // final carry, published in DONE

   logic [SLICE_WIDTH-1:0] slice_sum;
   logic                   slice_cry;

   adder_xbit_ahead #(
      .WIDTH (SLICE_WIDTH)
   ) u_slice (
      .a_i   (opa_q[SLICE_WIDTH-1:0]),
      .b_i   (opb_q[SLICE_WIDTH-1:0]),
      .cry_i (cry_q),
      .sum_o (slice_sum),
      .cry_o (slice_cry)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      cry_d   = cry_q;
      res_d   = res_q;
      ocry_d  = ocry_q;

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               opa_d   = i_num_a;
               opb_d   = i_num_b;
               cry_d   = i_cry;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end

         ST_CALC: begin
            // New slice enters at the top; after NUM_SLICES steps the first
            // (least-significant) slice has reached bit 0.
            res_d = (res_q >> SLICE_WIDTH)
                  | (DATA_WIDTH'(slice_sum) << (DATA_WIDTH - SLICE_WIDTH));
            opa_d = opa_q >> SLICE_WIDTH;
            opb_d = opb_q >> SLICE_WIDTH;
            cry_d = slice_cry;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               ocry_d  = slice_cry;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // Everything is held until the consumer takes the result.
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         cry_q   <= 1'b0;
         res_q   <= '0;
         ocry_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         cry_q   <= cry_d;
         res_q   <= res_d;
         ocry_q  <= ocry_d;
      end
   end

   // Handshake outputs are decoded from state only, so neither i_valid nor
   // i_ready reaches an output combinationally.
   assign o_ready = (state_q == ST_IDLE);
   assign o_valid = (state_q == ST_DONE);
   assign o_busy  = (state_q == ST_CALC) || (state_q == ST_DONE);
   assign o_res   = res_q;
   assign o_cry   = ocry_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
module tb_adder_seq_ctrl;

   localparam int DW = 32;
   localparam int SW = 8;
   localparam int NS = DW / SW;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_valid;
   logic          o_ready;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          i_cry;
   logic          o_valid;
   logic          i_ready;
   logic [DW-1:0] o_res;
   logic          o_cry;
   logic          o_busy;

   adder_seq_ctrl #(
      .DATA_WIDTH  (DW),
      .SLICE_WIDTH (SW)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_num_a (a),
      .i_num_b (b),
      .i_cry   (i_cry),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_res   (o_res),
      .o_cry   (o_cry),
      .o_busy  (o_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;
   int rdy_mode = 0;   // 0: always ready, 1: hold off, 2: random

   typedef struct {
      logic [DW-1:0] res;
      logic          cry;
      int            acc;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Consumer ready generator.
   initial begin
      i_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'b0;
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops an expectation on each o_valid rise and checks hold stability.
   initial begin : mon
      logic          prev_v;
      logic [DW-1:0] cap_r;
      logic          cap_c;
      exp_t          e;
      prev_v = 1'b0;
      cap_r  = '0;
      cap_c  = 1'b0;
      forever begin
         @(negedge clk);
         if (o_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_valid", 64'(o_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("res", 64'(o_res), 64'(e.res));
               chk("cry", 64'(o_cry), 64'(e.cry));
               chk("latency", 64'(cyc - e.acc), 64'(NS));
            end
            cap_r = o_res;
            cap_c = o_cry;
         end else if (o_valid && prev_v) begin
            chk("hold_res", 64'(o_res), 64'(cap_r));
            chk("hold_cry", 64'(o_cry), 64'(cap_c));
         end
         prev_v = o_valid;
      end
   end

   task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic cv,
                       input logic [DW-1:0] er, input logic ec);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      i_valid = 1'b1;
      a       = av;
      b       = bv;
      i_cry   = cv;
      while (!o_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!o_ready) begin
         chk("accept_timeout", 64'(o_ready), 64'd1);
         i_valid = 1'b0;
      end else begin
         e.res = er;
         e.cry = ec;
         e.acc = cyc + 1;
         sb.push_back(e);
         @(negedge clk);
         i_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sb.size() != 0 || o_valid) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] av, bv, er;
      logic          cv, ec;
      int            waited;

      rst     = 1'b1;
      i_valid = 1'b0;
      a       = '0;
      b       = '0;
      i_cry   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(o_ready), 64'd1);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_busy",  64'(o_busy),  64'd0);
      chk("rst_res",   64'(o_res),   64'd0);
      chk("rst_cry",   64'(o_cry),   64'd0);
      rst = 1'b0;

      // Carry ripple across a slice boundary.
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
      chk("busy_calc", 64'(o_busy), 64'd1);
      drain();
      chk("busy_idle", 64'(o_busy), 64'd0);

      // Carry-in only, and a no-carry pattern.
      send(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);
      send(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0);
      drain();

      // Backpressure with a competing request held on the input.
      rdy_mode = 1;
      send(32'h0000_0F0F, 32'h0000_F0F0, 1'b0, 32'h0000_FFFF, 1'b0);
      a       = 32'hDEAD_BEEF;
      b       = 32'h1111_1111;
      i_cry   = 1'b1;
      i_valid = 1'b1;
      waited  = 0;
      while (!o_valid && waited < 20) begin
         chk("ready_low_calc", 64'(o_ready), 64'd0);
         @(negedge clk);
         waited++;
      end
      repeat (5) begin
         chk("ready_low_done", 64'(o_ready), 64'd0);
         chk("valid_held", 64'(o_valid), 64'd1);
         @(negedge clk);
      end
      rdy_mode = 0;
      send(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 32'hEFBE_D001, 1'b0);
      drain();

      // Full wrap cases.
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Reset in the second CALC cycle aborts the request.
      send(32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 32'h0000_0000, 1'b1);
      @(negedge clk);
      sb.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 64'(o_ready), 64'd1);
      chk("abort_valid", 64'(o_valid), 64'd0);
      chk("abort_busy",  64'(o_busy),  64'd0);
      chk("abort_res",   64'(o_res),   64'd0);
      chk("abort_cry",   64'(o_cry),   64'd0);
      repeat (8) @(negedge clk);
      send(32'd3, 32'd4, 1'b0, 32'd7, 1'b0);
      drain();

      // Random regression with request gaps and random consumer stalls.
      rdy_mode = 2;
      for (int n = 0; n < 1000; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         av = $urandom;
         bv = $urandom;
         cv = 1'($urandom_range(0, 1));
         {ec, er} = {1'b0, av} + {1'b0, bv} + 33'(cv);
         send(av, bv, cv, er, ec);
      end
      rdy_mode = 0;
      drain();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
